// File: rtl/ps2_key_fifo.sv
// PS/2 set-2 byte decoder feeding a show-ahead event FIFO for MIO_BUS.
// Each event is {brk, ext, code[7:0]}; a CPU read pops the head.
module ps2_key_fifo #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    ps2_byte,
  input  logic          ps2_ready,
  input  logic          rd,
  input  logic          clr_ovf,
  output logic [9:0]    key_out,
  output logic          key_valid,
  output logic          full,
  output logic          overflow,
  output logic [AW:0]   count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXTBRK,
    S_SKIP
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      skip_q, skip_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            rdy_q;
  logic            byte_stb;
  logic            push_req;
  logic [9:0]      push_data;

  logic [9:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            is_full;
  logic            pop;
  logic            push_ok;
  logic            drop;

  // Keyboard status/ack bytes that never carry a keystroke.
  function automatic logic is_status(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  assign byte_stb = ps2_ready & ~rdy_q;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    tmo_d     = tmo_q;
    push_req  = 1'b0;
    push_data = '0;
    if (byte_stb) begin
      tmo_d = '0;
      case (state_q)
        S_IDLE: begin
          if (ps2_byte == 8'hE0) begin
            state_d = S_EXT;
          end else if (ps2_byte == 8'hF0) begin
            state_d = S_BRK;
          end else if (ps2_byte == 8'hE1) begin
            state_d = S_SKIP;
            skip_d  = 3'd7;
          end else if (!is_status(ps2_byte)) begin
            push_req  = 1'b1;
            push_data = {2'b00, ps2_byte};
          end
        end
        S_EXT: begin
          if (ps2_byte == 8'hF0) begin
            state_d = S_EXTBRK;
          end else if (ps2_byte != 8'hE0) begin
            push_req  = 1'b1;
            push_data = {2'b01, ps2_byte};
            state_d   = S_IDLE;
          end
        end
        S_BRK: begin
          push_req  = 1'b1;
          push_data = {2'b10, ps2_byte};
          state_d   = S_IDLE;
        end
        S_EXTBRK: begin
          push_req  = 1'b1;
          push_data = {2'b11, ps2_byte};
          state_d   = S_IDLE;
        end
        S_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
      // A stalled prefix is abandoned so the next byte starts fresh.
      state_d = S_IDLE;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_comb begin
    is_full  = (count_q == (AW+1)'(DEPTH));
    pop      = rd && (count_q != '0);
    push_ok  = push_req && (!is_full || pop);
    drop     = push_req && is_full && !pop;
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // A drop in the same cycle as clr_ovf keeps the flag set.
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
    else              ovf_d = ovf_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      skip_q   <= '0;
      tmo_q    <= '0;
      rdy_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      tmo_q    <= tmo_d;
      rdy_q    <= ps2_ready;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign key_valid = (count_q != '0);
  assign key_out   = key_valid ? mem_q[rd_ptr_q] : 10'h000;
  assign full      = is_full;
  assign overflow  = ovf_q;
  assign count     = count_q;

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Randomised + directed bench for ps2_key_fifo; a queue-based event model is
// checked by a negedge monitor that pops expected events on each read.
module tb_ps2_key_fifo;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TMO   = 16;

  logic          clk;
  logic          rst;
  logic [7:0]    ps2_byte;
  logic          ps2_ready;
  logic          rd;
  logic          clr_ovf;
  logic [9:0]    key_out;
  logic          key_valid;
  logic          full;
  logic          overflow;
  logic [AW:0]   count;

  ps2_key_fifo #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_byte  (ps2_byte),
    .ps2_ready (ps2_ready),
    .rd        (rd),
    .clr_ovf   (clr_ovf),
    .key_out   (key_out),
    .key_valid (key_valid),
    .full      (full),
    .overflow  (overflow),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] exp_q[$];
  bit m_ovf, m_prev, m_ext, m_brk;
  int m_skip, m_gap;
  int n_checks, n_fail;
  bit mon_en;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_status(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  endfunction

  // Reference decoder: prefix flags + skip budget, one call per received byte.
  task automatic decode(input logic [7:0] b, output bit have, output logic [9:0] ev);
    have = 0;
    ev   = '0;
    if (m_skip > 0) m_skip--;
    else if (m_brk) begin
      have = 1; ev = {1'b1, m_ext, b}; m_brk = 0; m_ext = 0;
    end
    else if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_ext) begin
      have = 1; ev = {2'b01, b}; m_ext = 0;
    end
    else if (b == 8'hE1) m_skip = 7;
    else if (!is_status(b)) begin
      have = 1; ev = {2'b00, b};
    end
  endtask

  task automatic step(input logic [7:0] b, input bit rdy, input bit r, input bit c, input bit rs);
    bit stb, drop, have;
    logic [9:0] ev;
    ps2_byte = b; ps2_ready = rdy; rd = r; clr_ovf = c; rst = rs;
    @(posedge clk); #1;
    if (rs) begin
      exp_q.delete();
      m_ovf = 0; m_prev = 0; m_ext = 0; m_brk = 0; m_skip = 0; m_gap = 0;
      return;
    end
    stb = rdy && !m_prev;
    m_prev = rdy;
    drop = 0;
    if (stb) begin
      m_gap = 0;
      decode(b, have, ev);
      if (have) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(ev);
        else drop = 1;
      end
    end else if (m_ext || m_brk || m_skip > 0) begin
      m_gap++;
      if (m_gap >= TMO) begin
        m_ext = 0; m_brk = 0; m_skip = 0;
      end
    end
    if (drop) m_ovf = 1;
    else if (c) m_ovf = 0;
  endtask

  task automatic send(input logic [7:0] b);
    step(b, 1, 0, 0, 0);
    step(b, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(8'h00, 0, 1, 0, 0);
  endtask

  // Monitor: compares outputs against the model, pops on each effective read.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("key_valid", int'(key_valid), int'(exp_q.size() > 0));
      if (exp_q.size() > 0) chk("key_out", int'(key_out), int'(exp_q[0]));
      else                  chk("key_out_empty", int'(key_out), 0);
      chk("count", int'(count), exp_q.size());
      chk("full", int'(full), int'(exp_q.size() == DEPTH));
      chk("overflow", int'(overflow), int'(m_ovf));
      if (!rst && rd && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] filt [11];
    logic [7:0] b;
    int hold, gap, rd_div, sel;
    filt = '{8'hAA, 8'hFA, 8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h29};
    n_checks = 0; n_fail = 0; mon_en = 0;
    ps2_byte = '0; ps2_ready = 0; rd = 0; clr_ovf = 0; rst = 1;

    step(8'h00, 0, 0, 0, 1);
    step(8'h00, 0, 0, 0, 1);
    step(8'h00, 0, 0, 0, 0);
    mon_en = 1;
    chk("reset_key_out", int'(key_out), 0);
    chk("reset_key_valid", int'(key_valid), 0);
    chk("reset_count", int'(count), 0);
    chk("reset_full", int'(full), 0);
    chk("reset_overflow", int'(overflow), 0);

    // Make code, visible one cycle after the strobe.
    step(8'h1C, 1, 0, 0, 0);
    chk("make_key_out", int'(key_out), 'h01C);
    chk("make_count", int'(count), 1);
    step(8'h1C, 0, 0, 0, 0);
    step(8'h00, 0, 1, 0, 0);
    chk("make_pop_valid", int'(key_valid), 0);
    chk("make_pop_key", int'(key_out), 0);

    // Extended break then extended make.
    send(8'hE0); send(8'hF0); send(8'h74);
    chk("extbrk_key", int'(key_out), 'h374);
    send(8'hE0); send(8'h75);
    chk("ext_count", int'(count), 2);
    step(8'h00, 0, 1, 0, 0);
    chk("ext_second", int'(key_out), 'h175);
    drain();

    // Status bytes and pause sequence yield nothing.
    foreach (filt[i]) send(filt[i]);
    chk("filter_count", int'(count), 1);
    chk("filter_key", int'(key_out), 'h029);
    drain();

    // Overflow with no reads.
    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("ovf_full", int'(full), 1);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_head", int'(key_out), 'h001);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_order", int'(key_out), i);
      step(8'h00, 0, 1, 0, 0);
    end
    chk("ovf_empty", int'(key_valid), 0);
    step(8'h00, 0, 0, 1, 0);
    chk("ovf_clear", int'(overflow), 0);

    // Full FIFO: push coincident with read.
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i));
    step(8'h20, 1, 1, 0, 0);
    chk("full_rw_count", int'(count), 8);
    chk("full_rw_ovf", int'(overflow), 0);
    step(8'h20, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(8'h00, 0, 1, 0, 0);
    chk("full_rw_tail", int'(key_out), 'h020);
    drain();

    // Read on empty.
    step(8'h00, 0, 1, 0, 0);
    chk("empty_rd_count", int'(count), 0);

    // Level-held ready gives one push.
    for (int i = 0; i < 10; i++) step(8'h15, 1, 0, 0, 0);
    step(8'h15, 0, 0, 0, 0);
    chk("level_count", int'(count), 1);
    drain();

    // Stalled break prefix times out.
    send(8'hF0);
    for (int i = 0; i < TMO + 4; i++) step(8'h00, 0, 0, 0, 0);
    send(8'h1C);
    chk("timeout_make", int'(key_out), 'h01C);
    drain();

    // Reset mid-sequence.
    send(8'h33);
    send(8'hE0);
    step(8'h00, 0, 0, 0, 1);
    chk("rst_key_out", int'(key_out), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(key_valid), 0);
    send(8'h1C);
    chk("rst_idle_make", int'(key_out), 'h01C);
    drain();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rd_div = (i < 200) ? 16 : 3;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'hE1;
        3: b = ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA;
        default: b = 8'($urandom);
      endcase
      hold = $urandom_range(1, 3);
      gap  = ($urandom_range(0, 15) == 0) ? TMO + 4 : $urandom_range(1, 3);
      for (int h = 0; h < hold; h++)
        step(b, 1, $urandom_range(0, rd_div - 1) == 0, $urandom_range(0, 19) == 0,
             $urandom_range(0, 499) == 0);
      for (int g = 0; g < gap; g++)
        step(b, 0, $urandom_range(0, rd_div - 1) == 0, $urandom_range(0, 19) == 0, 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
